vend_credit_fsm: RTL



---
 rtl/vend_credit_fsm.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vend_credit_fsm.sv
// Credit accumulator and vending control FSM fed by the coin decoder.
// Optional idle auto-refund is enabled by defining AUTO_REFUND_EN.
module vend_credit_fsm #(
  parameter int CREDIT_W       = 6,
  parameter int MAX_CREDIT     = 50,
  parameter int PRICE0         = 8,
  parameter int PRICE1         = 12,
  parameter int PRICE2         = 15,
  parameter int PRICE3         = 20,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [3:0]          coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [1:0]          dispense_item,
  output logic                change_valid,
  output logic [3:0]          change_coin,
  output logic                coin_reject,
  output logic                busy
);

  localparam int CW1 = CREDIT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          item_q, item_d;
  logic                rej_q, rej_d;

  logic [CW1-1:0] credit_x, coin_x, sum_x, price_x;
  logic [3:0]     chg_w;
  logic           coin_legal, coin_ok;

  function automatic logic [CW1-1:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = CW1'(PRICE0);
      2'd1:    price_of = CW1'(PRICE1);
      2'd2:    price_of = CW1'(PRICE2);
      default: price_of = CW1'(PRICE3);
    endcase
  endfunction

  // All credit arithmetic is done one bit wider so the MAX_CREDIT check cannot wrap.
  assign credit_x   = {1'b0, credit_q};
  assign coin_x     = CW1'(coin_value);
  assign sum_x      = credit_x + coin_x;
  assign price_x    = price_of(sel_item);
  assign coin_legal = (coin_value == 4'd1) || (coin_value == 4'd5) || (coin_value == 4'd10);
  assign coin_ok    = coin_legal && (sum_x <= CW1'(MAX_CREDIT));
  assign chg_w      = (credit_x >= CW1'(10)) ? 4'd10 :
                      (credit_x >= CW1'(5))  ? 4'd5  : 4'd1;

`ifdef AUTO_REFUND_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_d        = item_q;
    rej_d         = 1'b0;
    dispense      = 1'b0;
    dispense_item = 2'd0;
    change_valid  = 1'b0;
    change_coin   = 4'd0;
`ifdef AUTO_REFUND_EN
    cnt_d         = '0;
`endif
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel && state_q == S_COLLECT) begin
          state_d = S_CHANGE;
          rej_d   = coin_valid;
        end else if (sel_valid && state_q == S_COLLECT && credit_x >= price_x) begin
          credit_d = credit_q - CREDIT_W'(price_x);
          item_d   = sel_item;
          state_d  = S_DISPENSE;
          rej_d    = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = sum_x[CREDIT_W-1:0];
            state_d  = S_COLLECT;
          end else begin
            rej_d = 1'b1;
          end
        end
`ifdef AUTO_REFUND_EN
        // Any select strobe counts as activity, even one ignored for low credit.
        if (state_q == S_COLLECT && !cancel && !sel_valid && !(coin_valid && coin_ok)) begin
          if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) state_d = S_CHANGE;
          else cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DISPENSE: begin
        dispense      = 1'b1;
        dispense_item = item_q;
        rej_d         = coin_valid;
        state_d       = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        rej_d = coin_valid;
        if (credit_q != '0) begin
          change_valid = 1'b1;
          change_coin  = chg_w;
          credit_d     = credit_q - CREDIT_W'(chg_w);
        end
        if (credit_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      item_q   <= 2'd0;
      rej_q    <= 1'b0;
`ifdef AUTO_REFUND_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      rej_q    <= rej_d;
`ifdef AUTO_REFUND_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign credit      = credit_q;
  assign coin_reject = rej_q;
  assign busy        = (state_q == S_DISPENSE) || (state_q == S_CHANGE);

endmodule
